// File: rtl/bcd_display_scanner_pkg.sv
// Shared segment encodings (active-low, bit order {g,f,e,d,c,b,a}) and a width helper
// for the BCD display scanner.
package bcd_display_scanner_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bits needed to count 0..value-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/bcd_display_scanner_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes A-F show a dash.
module bcd_to_seg7
  import bcd_display_scanner_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed common-anode BCD display scanner with slot blanking and decimal points.
// Optional leading-zero suppression is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    scan_en,
  input  logic                    latch_en,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = clog2(NUM_DIGITS);
  localparam int unsigned PRE_W = clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_BLANK = PRE_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [PRE_W-1:0]        prescaler, pre_next;
  logic [IDX_W-1:0]        index, idx_next;
  logic                    wrap_frame;
  logic [3:0]              cur_code;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [7:0]              seg_next;
  logic [NUM_DIGITS-1:0]   sel_next;

  assign cur_code = shadow_digits[4*index +: 4];

  bcd_to_seg7 decoder (
    .code (cur_code),
    .seg  (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_run;

  // Walk down from the most significant digit; the run ends at the first non-zero code.
  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run    = zero_run && (shadow_digits[4*k +: 4] == 4'd0);
      lz_blank[k] = zero_run;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    pre_next   = prescaler;
    idx_next   = index;
    wrap_frame = 1'b0;
    if (scan_en) begin
      if (prescaler == PRE_LAST) begin
        pre_next = '0;
        if (index == IDX_LAST) begin
          idx_next   = '0;
          wrap_frame = 1'b1;
        end else begin
          idx_next = index + 1'b1;
        end
      end else begin
        pre_next = prescaler + 1'b1;
      end
    end
  end

  always_comb begin
    seg_next = '1;
    sel_next = '0;
    if (scan_en && (prescaler >= PRE_BLANK)) begin
      sel_next[index] = 1'b1;
      seg_next        = {~shadow_dp[index], lz_blank[index] ? SEG_BLANK : cur_seg};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      prescaler     <= '0;
      index         <= '0;
      seg_n         <= '1;
      digit_sel     <= '0;
      frame_done    <= 1'b0;
    end else begin
      if (latch_en) begin
        shadow_digits <= digits_in;
        shadow_dp     <= dp_mask;
      end
      prescaler  <= pre_next;
      index      <= idx_next;
      seg_n      <= seg_next;
      digit_sel  <= sel_next;
      frame_done <= wrap_frame;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Table-driven bench for bcd_display_scanner (4 digits, 4 clocks per slot, 1 blank clock).
module tb_bcd_display_scanner;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        scan_en = 1'b0;
  logic        latch_en = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_mask = '0;
  logic [7:0]  seg_n;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        scan;
    logic        latch;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        fd;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  bcd_display_scanner #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .scan_en    (scan_en),
    .latch_en   (latch_en),
    .digits_in  (digits_in),
    .dp_mask    (dp_mask),
    .seg_n      (seg_n),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  function automatic void add(input logic scan, input logic latch, input logic [15:0] d,
                              input logic [3:0] dp, input logic [7:0] seg,
                              input logic [3:0] sel, input logic fd);
    vec_t v;
    v.scan = scan; v.latch = latch; v.digits = d; v.dp = dp;
    v.seg = seg; v.sel = sel; v.fd = fd;
    vecs.push_back(v);
  endfunction

  // One full frame: per slot one blank clock then three lit clocks; optional latch on the first row.
  // Non-latch rows drive junk on digits_in/dp_mask, which must be ignored.
  function automatic void add_frame(input logic latch, input logic [15:0] d, input logic [3:0] dp,
                                    input logic [31:0] segs);
    logic [3:0] sel;
    for (int s = 0; s < 4; s++) begin
      sel = 4'b0001 << s;
      if (latch && s == 0) add(1'b1, 1'b1, d, dp, 8'hFF, 4'b0000, 1'b0);
      else                 add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hFF, 4'b0000, 1'b0);
      for (int r = 0; r < 3; r++)
        add(1'b1, 1'b0, 16'hFFFF, 4'hF, segs[8*s +: 8], sel, (s == 3 && r == 2));
    end
  endfunction

  task automatic check_now(input string name, input logic [7:0] seg, input logic [3:0] sel,
                           input logic fd);
    checks++;
    if ({seg_n, digit_sel, frame_done} !== {seg, sel, fd}) begin
      failures++;
      $display("FAIL %s: seg_n=%h digit_sel=%b frame_done=%b, expected seg_n=%h digit_sel=%b frame_done=%b",
               name, seg_n, digit_sel, frame_done, seg, sel, fd);
    end
  endtask

  task automatic run_vecs(input int first, input int last);
    for (int i = first; i < last; i++) begin
      scan_en   = vecs[i].scan;
      latch_en  = vecs[i].latch;
      digits_in = vecs[i].digits;
      dp_mask   = vecs[i].dp;
      @(negedge clock);
      checks++;
      if ({seg_n, digit_sel, frame_done} !== {vecs[i].seg, vecs[i].sel, vecs[i].fd}) begin
        failures++;
        $display("FAIL vec%0d: seg_n=%h digit_sel=%b frame_done=%b, expected seg_n=%h digit_sel=%b frame_done=%b",
                 i, seg_n, digit_sel, frame_done, vecs[i].seg, vecs[i].sel, vecs[i].fd);
      end
    end
  endtask

  initial begin
    int part1_end;

    #1 reset = 1'b1;
    #1 check_now("reset_init", 8'hFF, 4'b0000, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // Load 1234 while scan is off, then one plain frame.
    add(1'b0, 1'b1, 16'h1234, 4'b0000, 8'hFF, 4'b0000, 1'b0);
    add_frame(1'b0, 16'h0000, 4'h0, {8'hF9, 8'hA4, 8'hB0, 8'h99});
    // Invalid code on digit 1 and a decimal point on digit 2.
    add_frame(1'b1, 16'h12B4, 4'b0100, {8'hF9, 8'h24, 8'hBF, 8'h99});
`ifdef LEADING_ZERO_BLANK_EN
    add_frame(1'b1, 16'h0050, 4'b0000, {8'hFF, 8'hFF, 8'h92, 8'hC0});
    add_frame(1'b1, 16'h0000, 4'b0000, {8'hFF, 8'hFF, 8'hFF, 8'hC0});
`else
    add_frame(1'b1, 16'h0050, 4'b0000, {8'hC0, 8'hC0, 8'h92, 8'hC0});
    add_frame(1'b1, 16'h0000, 4'b0000, {8'hC0, 8'hC0, 8'hC0, 8'hC0});
`endif

    // Scan paused in slot 2 at prescaler 2; a latch lands during the pause.
    add(1'b1, 1'b1, 16'h1234, 4'b0000, 8'hFF, 4'b0000, 1'b0);
    for (int r = 0; r < 3; r++) add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'h99, 4'b0001, 1'b0);
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hFF, 4'b0000, 1'b0);
    for (int r = 0; r < 3; r++) add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hB0, 4'b0010, 1'b0);
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hFF, 4'b0000, 1'b0);
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hA4, 4'b0100, 1'b0);
    for (int r = 0; r < 5; r++)
      add(1'b0, (r == 2), (r == 2) ? 16'h1734 : 16'hFFFF, (r == 2) ? 4'b0000 : 4'hF,
          8'hFF, 4'b0000, 1'b0);
    for (int r = 0; r < 2; r++) add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hF8, 4'b0100, 1'b0);
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hFF, 4'b0000, 1'b0);
    for (int r = 0; r < 3; r++) add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hF9, 4'b1000, (r == 2));

    // Latch on the edge that advances into slot 1: slot 1 shows the new digit 6.
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hFF, 4'b0000, 1'b0);
    for (int r = 0; r < 3; r++)
      add(1'b1, (r == 2), (r == 2) ? 16'h1764 : 16'hFFFF, (r == 2) ? 4'b0000 : 4'hF,
          8'h99, 4'b0001, 1'b0);
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hFF, 4'b0000, 1'b0);
    for (int r = 0; r < 3; r++) add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'h82, 4'b0010, 1'b0);
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hFF, 4'b0000, 1'b0);
    for (int r = 0; r < 3; r++) add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hF8, 4'b0100, 1'b0);
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hFF, 4'b0000, 1'b0);
    for (int r = 0; r < 3; r++) add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hF9, 4'b1000, (r == 2));

    part1_end = vecs.size();
    run_vecs(0, part1_end);

    // Mid-scan asynchronous reset while slot 0 is lit.
    scan_en  = 1'b1;
    latch_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_now("pre_reset_lit", 8'h99, 4'b0001, 1'b0);
    #2 reset = 1'b1;
    #1 check_now("reset_mid", 8'hFF, 4'b0000, 1'b0);
    @(negedge clock);
    check_now("reset_hold", 8'hFF, 4'b0000, 1'b0);
    reset = 1'b0;

    // After reset the shadow is cleared and the scan restarts at slot 0, prescaler 0.
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hFF, 4'b0000, 1'b0);
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hC0, 4'b0001, 1'b0);
    add(1'b1, 1'b0, 16'hFFFF, 4'hF, 8'hC0, 4'b0001, 1'b0);
    run_vecs(part1_end, vecs.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
